// File: rtl/reg_display_scanner.sv
// Register-select hex display scanner: manual or auto-scan selection of one of NREGS registers,
// with freeze, optional leading-zero blanking and registered active-low seven-segment outputs.
module reg_display_scanner #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned NREGS    = 8,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned DWELL    = 50_000_000,
    parameter int unsigned BLANK_LZ = 0
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [SEL_W-1:0]         sw,
    input  logic                     mode,
    input  logic                     hold,
    input  logic [NREGS*WIDTH-1:0]   regs,
    output logic [7*(WIDTH/4)-1:0]   displ,
    output logic [SEL_W-1:0]         sel_out
);

    localparam int unsigned DIGITS = WIDTH / 4;
    localparam int unsigned CNT_W  = $clog2(DWELL);

    typedef enum logic [1:0] {StManual, StAuto, StFrozen} state_e;

    state_e                  state_q, state_d;
    logic [SEL_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [7*DIGITS-1:0]     displ_q, displ_d;

    logic [SEL_W-1:0]        sw_cl;
    logic [SEL_W-1:0]        step_idx;
    logic [CNT_W-1:0]        step_cnt;
    logic [WIDTH-1:0]        cur_val;

    function automatic logic [6:0] seg7(input logic [3:0] h);
        case (h)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    assign sw_cl = (32'(sw) >= NREGS) ? SEL_W'(NREGS - 1) : sw;

    // One auto-scan step: advance the index only on the dwell counter wrap.
    always_comb begin
        step_idx = idx_q;
        step_cnt = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DWELL - 1)) begin
            step_cnt = '0;
            step_idx = (idx_q == SEL_W'(NREGS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Releasing a freeze into AUTO resumes the scan where it stopped.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (hold) begin
            state_d = StFrozen;
        end else if (mode && (state_q != StManual)) begin
            state_d = StAuto;
            idx_d   = step_idx;
            cnt_d   = step_cnt;
        end else begin
            state_d = mode ? StAuto : StManual;
            idx_d   = sw_cl;
            cnt_d   = '0;
        end
    end

    always_comb begin
        logic       seen;
        logic [3:0] nib;
        seen    = 1'b0;
        nib     = '0;
        cur_val = regs[int'(idx_d) * WIDTH +: WIDTH];
        displ_d = '1;
        for (int d = int'(DIGITS) - 1; d >= 0; d--) begin
            nib = cur_val[4*d +: 4];
            if (nib != 4'h0 || d == 0) begin
                seen = 1'b1;
            end
            if (BLANK_LZ == 0 || seen) begin
                displ_d[7*d +: 7] = seg7(nib);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StManual;
            idx_q   <= '0;
            cnt_q   <= '0;
            displ_q <= '1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            if (!hold) begin
                displ_q <= displ_d;
            end
        end
    end

    assign displ   = displ_q;
    assign sel_out = idx_q;

endmodule

// File: tb/tb_reg_display_scanner.sv
// Randomized bench for reg_display_scanner: a value-level reference model checked every cycle,
// plus directed scenarios with literal expectations. Two instances differ only in blanking.
module tb_reg_display_scanner;

    localparam int unsigned W  = 16;
    localparam int unsigned N  = 6;
    localparam int unsigned SW = 3;
    localparam int unsigned DW = 4;
    localparam int unsigned D  = W / 4;

    logic              clock  = 1'b0;
    logic              resetn = 1'b0;
    logic [SW-1:0]     sw     = '0;
    logic              mode   = 1'b0;
    logic              hold   = 1'b0;
    logic [N*W-1:0]    regs   = '0;
    logic [7*D-1:0]    displ0, displ1;
    logic [SW-1:0]     sel0, sel1;

    always #5 clock = ~clock;

    reg_display_scanner #(
        .WIDTH(W), .NREGS(N), .SEL_W(SW), .DWELL(DW), .BLANK_LZ(0)
    ) dut0 (
        .clock(clock), .resetn(resetn), .sw(sw), .mode(mode), .hold(hold),
        .regs(regs), .displ(displ0), .sel_out(sel0)
    );

    reg_display_scanner #(
        .WIDTH(W), .NREGS(N), .SEL_W(SW), .DWELL(DW), .BLANK_LZ(1)
    ) dut1 (
        .clock(clock), .resetn(resetn), .sw(sw), .mode(mode), .hold(hold),
        .regs(regs), .displ(displ1), .sel_out(sel1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what is shown, not how the design stores it.
    bit           m_frozen = 0;
    bit           m_auto   = 0;
    bit           m_shown  = 0;
    int           m_idx    = 0;
    int           m_cnt    = 0;
    logic [W-1:0] m_val    = '0;

    function automatic logic [6:0] seg(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [7*D-1:0] exp_displ(input logic [W-1:0] v, input bit shown,
                                                  input bit blank);
        logic [7*D-1:0] r;
        int top;
        r   = '1;
        top = 0;
        if (!shown) return r;
        for (int d = 0; d < int'(D); d++) if (v[4*d +: 4] != 4'h0) top = d;
        for (int d = 0; d < int'(D); d++) if (!blank || d <= top) r[7*d +: 7] = seg(v[4*d +: 4]);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_frozen = 0; m_auto = 0; m_shown = 0; m_idx = 0; m_cnt = 0; m_val = '0;
        end else if (hold) begin
            m_frozen = 1;
        end else begin
            if (mode && (m_frozen || m_auto)) begin
                m_cnt++;
                if (m_cnt == int'(DW)) begin
                    m_cnt = 0;
                    m_idx = (m_idx + 1) % int'(N);
                end
            end else begin
                m_idx = (int'(sw) >= int'(N)) ? int'(N) - 1 : int'(sw);
                m_cnt = 0;
            end
            m_auto   = mode;
            m_frozen = 0;
            m_val    = regs[m_idx*W +: W];
            m_shown  = 1;
        end
    end

    always @(negedge clock) begin
        check("displ_plain", displ0, exp_displ(m_val, m_shown, 0));
        check("displ_blank", displ1, exp_displ(m_val, m_shown, 1));
        check("sel_plain",   sel0,   m_idx);
        check("sel_blank",   sel1,   m_idx);
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    initial begin
        int           saved_idx;
        logic [W-1:0] saved_val;
        logic [W-1:0] v;

        repeat (2) @(posedge clock);
        #2;
        // Reset in the middle of an auto scan.
        mode   = 1'b1;
        resetn = 1'b1;
        repeat (7) step();
        resetn = 1'b0;
        #1;
        check("rst_displ", displ0, 28'hFFF_FFFF);
        check("rst_sel",   sel0,   0);
        regs[0*W +: W] = 16'h1234;
        mode = 1'b0;
        sw   = '0;
        repeat (2) @(posedge clock);
        #3 resetn = 1'b1;
        #1 check("rel_before_edge", displ0, 28'hFFF_FFFF);
        @(posedge clock);
        #1 check("rel_first", displ0, {7'h79, 7'h24, 7'h30, 7'h19});
        #1;

        // Manual select with clamp.
        sw = 3'd7;
        regs[5*W +: W] = 16'hBEEF;
        @(posedge clock);
        #1 check("clamp_sel", sel0, 5);
        check("clamp_displ", displ0, {7'h03, 7'h06, 7'h06, 7'h0E});
        #1;

        // Auto scan from sw=2; sw toggles are ignored.
        sw   = 3'd2;
        mode = 1'b1;
        for (int k = 0; k < 4 * int'(N); k++) begin
            @(posedge clock);
            #1 check("scan_seq", sel0, (2 + k / 4) % int'(N));
            #1 sw = SW'($urandom);
        end

        // Hold asserted on the wrapping cycle.
        for (int g = 0; g < 2 * int'(DW) && m_cnt != int'(DW) - 1; g++) step();
        if (m_cnt != int'(DW) - 1) begin
            n_fail++;
            $display("FAIL wrap_search: got cnt %0d expected %0d", m_cnt, DW - 1);
        end
        saved_idx = m_idx;
        saved_val = m_val;
        hold = 1'b1;
        regs[saved_idx*W +: W] = 16'hA5A5;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1 check("hold_sel", sel0, saved_idx);
            check("hold_displ", displ0, exp_displ(saved_val, 1, 0));
            #1;
        end
        mode = 1'b0;
        sw   = 3'd1;
        hold = 1'b0;
        regs[1*W +: W] = 16'h0F80;
        @(posedge clock);
        #1 check("release_sel", sel0, 1);
        check("release_displ", displ0, {7'h40, 7'h0E, 7'h00, 7'h40});
        #1;

        // Leading-zero blanking.
        sw = 3'd0;
        regs[0*W +: W] = 16'h0030;
        @(posedge clock);
        #1 check("blank_0030", displ1, {7'h7F, 7'h7F, 7'h30, 7'h40});
        check("noblank_0030", displ0, {7'h40, 7'h40, 7'h30, 7'h40});
        #1 regs[0*W +: W] = 16'h0000;
        @(posedge clock);
        #1 check("blank_0000", displ1, {7'h7F, 7'h7F, 7'h7F, 7'h40});
        #1;

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            sw = SW'($urandom);
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            if ($urandom_range(0, 5) == 0) hold = ~hold;
            for (int r = 0; r < int'(N); r++) begin
                v = W'($urandom);
                case ($urandom_range(0, 3))
                    0: v = v & 16'h00FF;
                    1: v = v & 16'h000F;
                    2: v = '0;
                    default: ;
                endcase
                if ($urandom_range(0, 3) == 0) regs[r*W +: W] = v;
            end
            if ($urandom_range(0, 199) == 0) begin
                resetn = 1'b0;
                #1 resetn = 1'b1;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
